mul_share_arb: RTL and testbench

- Shares one signed 8x8 multiplier core among NUM_REQ requesters.
- Arbitration is round-robin.
- Each accepted request is sequenced through a fixed multi-cycle compute window, then the result is held until the consumer accepts it.
- Sits between the register/UART-facing requesters and the multiplier datapath. Exactly one operation is in flight at a time.

---
 rtl/mul_share_pkg.sv | 8 +
 rtl/mul_share_arb_if.sv | 26 ++
 rtl/mul_sm_core.sv | 17 +
 rtl/mul_share_arb.sv | 77 +++++++
 tb/tb_mul_share_arb.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared types and constants for the shared multiplier arbiter
package mul_share_pkg;
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;
    localparam int OPND_W = 8;
    localparam int PROD_W = 17;
    localparam logic [7:0] CHR_MINUS = 8'h2D;
    localparam logic [7:0] CHR_PLUS = 8'h2B;
endpackage

// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if: requester/consumer bundle; MUL_SHARE_ARB_SIGN_CHR_EN adds ASCII sign outputs
interface mul_share_arb_if #(parameter int NUM_REQ = 4, parameter int ID_W = 3);
    logic [NUM_REQ-1:0] req_valid;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0] req_ready;
    logic rsp_valid;
    logic rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [mul_share_pkg::PROD_W-1:0] rsp_prod;
    logic busy;
`ifdef MUL_SHARE_ARB_SIGN_CHR_EN
    logic [7:0] rsp_sgn_a;
    logic [7:0] rsp_sgn_b;
    logic [7:0] rsp_sgn_p;
    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input req_ready, rsp_valid, rsp_id, rsp_prod, busy, rsp_sgn_a, rsp_sgn_b, rsp_sgn_p);
    modport slave (input req_valid, req_a, req_b, rsp_ready,
                   output req_ready, rsp_valid, rsp_id, rsp_prod, busy, rsp_sgn_a, rsp_sgn_b, rsp_sgn_p);
`else
    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input req_ready, rsp_valid, rsp_id, rsp_prod, busy);
    modport slave (input req_valid, req_a, req_b, rsp_ready,
                   output req_ready, rsp_valid, rsp_id, rsp_prod, busy);
`endif
endinterface

// File: rtl/mul_sm_core.sv
// mul_sm_core: combinational signed 8x8 -> 17-bit multiply via sign-magnitude and negate
module mul_sm_core
    import mul_share_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p
);
    logic [OPND_W-1:0] ma, mb;
    logic [2*OPND_W-1:0] m;
    always_comb begin
        ma = a[OPND_W-1] ? -a : a;
        mb = b[OPND_W-1] ? -b : b;
        m = (2*OPND_W)'(ma) * (2*OPND_W)'(mb);
        p = (a[OPND_W-1] ^ b[OPND_W-1]) ? -{1'b0, m} : {1'b0, m};
    end
endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin sharing of one signed multiplier; MUL_SHARE_ARB_SIGN_CHR_EN adds ASCII sign outputs
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 2,
    parameter int ID_W = 3
) (
    input logic clk,
    input logic rst_n,
    mul_share_arb_if.slave bus
);
    state_e state;
    logic [2:0] cnt;
    logic [ID_W-1:0] rr_ptr, off, gid, id_q;
    logic [ID_W:0] sum;
    logic [NUM_REQ-1:0] rot;
    logic [OPND_W-1:0] a_q, b_q, a_g, b_g;
    logic [PROD_W-1:0] prod;
    // rotate so bit 0 is the rr pointer; lowest set bit is the winner offset
    always_comb begin
        rot = NUM_REQ'({2{bus.req_valid}} >> rr_ptr);
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) off = ID_W'(k);
        sum = {1'b0, rr_ptr} + {1'b0, off};
        gid = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
        a_g = OPND_W'(bus.req_a >> {gid, 3'b000});
        b_g = OPND_W'(bus.req_b >> {gid, 3'b000});
        bus.req_ready = (state == IDLE && |bus.req_valid) ? NUM_REQ'(1) << gid : '0;
    end
    assign bus.busy = state != IDLE;
    mul_sm_core u_core (.a(a_q), .b(b_q), .p(prod));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            rr_ptr <= '0;
            a_q <= '0;
            b_q <= '0;
            id_q <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id <= '0;
            bus.rsp_prod <= '0;
`ifdef MUL_SHARE_ARB_SIGN_CHR_EN
            bus.rsp_sgn_a <= CHR_PLUS;
            bus.rsp_sgn_b <= CHR_PLUS;
            bus.rsp_sgn_p <= CHR_PLUS;
`endif
        end else if (state == IDLE) begin
            if (|bus.req_valid) begin
                a_q <= a_g;
                b_q <= b_g;
                id_q <= gid;
                cnt <= 3'(MUL_LAT - 1);
                rr_ptr <= (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
                state <= CALC;
            end
        end else if (state == CALC) begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd0) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_id <= id_q;
                bus.rsp_prod <= prod;
`ifdef MUL_SHARE_ARB_SIGN_CHR_EN
                bus.rsp_sgn_a <= a_q[7] ? CHR_MINUS : CHR_PLUS;
                bus.rsp_sgn_b <= b_q[7] ? CHR_MINUS : CHR_PLUS;
                bus.rsp_sgn_p <= (a_q[7] ^ b_q[7]) ? CHR_MINUS : CHR_PLUS;
`endif
                state <= HOLD;
            end
        end else if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed stimulus against a transaction-level model of the shared multiplier
module tb_mul_share_arb;
    localparam int NUM_REQ = 4;
    localparam int MUL_LAT = 2;
    localparam int ID_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_share_arb_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();
    mul_share_arb #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        return -1;
    endfunction

    // model: one job at a time, MUL_LAT edges to result, held until consumer takes it
    bit m_on = 0, m_busy = 0, e_valid = 0;
    int m_left = 0, m_ptr = 0, m_id = 0, m_w = 0;
    logic signed [7:0] m_a, m_b;
    logic [16:0] e_prod = '0;
    logic [ID_W-1:0] e_id = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on = 1; m_busy = 0; m_left = 0; m_ptr = 0;
            e_valid = 0; e_id = '0; e_prod = '0;
        end else if (m_on) begin
            if (!m_busy) begin
                m_w = winner(bus.req_valid, m_ptr);
                if (m_w >= 0) begin
                    m_busy = 1; m_left = MUL_LAT; m_id = m_w;
                    m_ptr = (m_w + 1) % NUM_REQ;
                    m_a = bus.req_a[m_w*8 +: 8];
                    m_b = bus.req_b[m_w*8 +: 8];
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    e_valid = 1;
                    e_id = ID_W'(m_id);
                    e_prod = 17'(int'(m_a) * int'(m_b));
                end
            end else if (bus.rsp_ready) begin
                e_valid = 0;
                m_busy = 0;
            end
        end
    end

    int c_w;
    logic [NUM_REQ-1:0] c_rr;
    always @(negedge clk) begin
        if (m_on) begin
            c_w = winner(bus.req_valid, m_ptr);
            c_rr = (!m_busy && c_w >= 0) ? NUM_REQ'(1) << c_w : '0;
            chk("req_ready", 32'(bus.req_ready), 32'(c_rr));
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid));
            chk("rsp_id", 32'(bus.rsp_id), 32'(e_id));
            chk("rsp_prod", 32'(bus.rsp_prod), 32'(e_prod));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int i);
        int n = 0;
        #1;
        while (!bus.req_ready[i] && n < 50) begin
            tick();
            #1;
            n++;
        end
        chk("grant_wait", 32'(n < 50), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
        chk("idle_wait", 32'(n < 50), 32'd1);
    endtask

    task automatic serve(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [16:0] lit, input bit poke);
        int n = 0;
        bus.req_valid[i] = 1'b1;
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
        wait_grant(i);
        tick();
        bus.req_valid[i] = 1'b0;
        if (poke) bus.req_a[i*8 +: 8] = ~a;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(MUL_LAT));
        chk("prod_lit", 32'(bus.rsp_prod), 32'(lit));
        chk("id_lit", 32'(bus.rsp_id), 32'(i));
        tick();
        chk("rsp_clear", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    int g, n;
    int order[5];
    int exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_prod", 32'(bus.rsp_prod), 32'd0);
        chk("rst_id", 32'(bus.rsp_id), 32'd0);
`ifdef MUL_SHARE_ARB_SIGN_CHR_EN
        chk("rst_sgn_p", 32'(bus.rsp_sgn_p), 32'h2B);
`endif
        serve(0, 8'd7, 8'd6, 17'd42, 1'b0);
        serve(1, 8'hFB, 8'd9, 17'h1FFD3, 1'b0);
`ifdef MUL_SHARE_ARB_SIGN_CHR_EN
        chk("sgn_p", 32'(bus.rsp_sgn_p), 32'h2D);
        chk("sgn_b", 32'(bus.rsp_sgn_b), 32'h2B);
        chk("sgn_a", 32'(bus.rsp_sgn_a), 32'h2D);
`endif
        serve(2, 8'h80, 8'h80, 17'h04000, 1'b0);
        serve(3, 8'h00, 8'hF9, 17'h00000, 1'b0);

        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*8 +: 8] = 8'(i + 1);
            bus.req_b[i*8 +: 8] = 8'(8'hF0 + i);
        end
        bus.req_valid = '1;
        g = 0;
        n = 0;
        while (g < 5 && n < 100) begin
            #1;
            if (|bus.req_ready) begin
                for (int k = 0; k < NUM_REQ; k++)
                    if (bus.req_ready[k]) order[g] = k;
                g++;
            end
            tick();
            n++;
        end
        bus.req_valid = '0;
        chk("rr_count", 32'(g), 32'd5);
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(order[k]), 32'(exp_ord[k]));
        wait_idle();

        serve(1, 8'h03, 8'hFC, 17'h1FFF4, 1'b1);

        bus.rsp_ready = 1'b0;
        bus.req_valid[2] = 1'b1;
        bus.req_a[16 +: 8] = 8'h0C;
        bus.req_b[16 +: 8] = 8'h0B;
        wait_grant(2);
        tick();
        bus.req_valid[2] = 1'b0;
        bus.req_valid[0] = 1'b1;
        bus.req_a[0 +: 8] = 8'd2;
        bus.req_b[0 +: 8] = 8'd2;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        repeat (10) begin
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_prod", 32'(bus.rsp_prod), 32'd132);
            chk("bp_id", 32'(bus.rsp_id), 32'd2);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp_release", 32'(bus.rsp_valid), 32'd0);
        wait_grant(0);
        tick();
        bus.req_valid[0] = 1'b0;
        wait_idle();
        tick();

        bus.req_valid[2] = 1'b1;
        bus.req_a[16 +: 8] = 8'd5;
        bus.req_b[16 +: 8] = 8'd5;
        wait_grant(2);
        tick();
        bus.req_valid[2] = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_prod", 32'(bus.rsp_prod), 32'd0);
        chk("mid_rst_id", 32'(bus.rsp_id), 32'd0);
        repeat (5) begin
            chk("no_rsp", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        bus.req_valid[1] = 1'b1;
        bus.req_valid[3] = 1'b1;
        #1;
        chk("ptr0_grant", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = '0;
        wait_idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
